// File: rtl/pop_mon_if.sv
// POP gate lines plus the measurement results of pop_sequence_monitor.
// The master side is the POP timer / bench; the slave side is the monitor.
interface pop_mon_if #(
    parameter int CNT_W = 16
);
    logic             pump;
    logic             probe;
    logic             MW;
    logic             sample;
    logic [CNT_W-1:0] pump_len;
    logic [CNT_W-1:0] mw1_len;
    logic [CNT_W-1:0] ramsey_len;
    logic [CNT_W-1:0] mw2_len;
    logic [CNT_W-1:0] probe_len;
    logic             result_valid;
    logic             seq_error;
    logic [2:0]       error_code;
    logic [15:0]      cycle_count;

    modport master (
        output pump, probe, MW, sample,
        input  pump_len, mw1_len, ramsey_len, mw2_len, probe_len,
        input  result_valid, seq_error, error_code, cycle_count
    );

    modport slave (
        input  pump, probe, MW, sample,
        output pump_len, mw1_len, ramsey_len, mw2_len, probe_len,
        output result_valid, seq_error, error_code, cycle_count
    );
endinterface

// File: rtl/pop_sequence_monitor.sv
// Passive POP cycle checker: measures every phase width and flags malformed cycles.
// Define POP_MON_SAMPLE_CHECK_EN to require sample high throughout the probe window.
module pop_sequence_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic     clk,
    input  logic     reset,
    pop_mon_if.slave pop_io
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PUMP, S_WAIT_MW1, S_MW1, S_RAMSEY, S_MW2, S_WAIT_PROBE, S_PROBE
    } state_t;

    state_t           state_q;
    logic             r_pump_q, p_pump_q, r_mw_q, p_mw_q, r_probe_q, p_probe_q;
    logic             live_q, armed_q;
    logic [TMO_W-1:0] tmo_q;
    logic [CNT_W-1:0] pump_cnt_q, mw1_cnt_q, ramsey_cnt_q, mw2_cnt_q, probe_cnt_q;
    logic [CNT_W-1:0] pump_len_q, mw1_len_q, ramsey_len_q, mw2_len_q, probe_len_q;
    logic             result_valid_q, seq_error_q;
    logic [2:0]       error_code_q, err_d;
    logic [15:0]      cycle_count_q;
    logic             pump_rise, pump_fall, mw_rise, mw_fall, probe_rise, probe_fall;
    logic             sample_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign pump_rise  = r_pump_q & ~p_pump_q;
    assign pump_fall  = ~r_pump_q & p_pump_q;
    assign mw_rise    = r_mw_q & ~p_mw_q;
    assign mw_fall    = ~r_mw_q & p_mw_q;
    assign probe_rise = r_probe_q & ~p_probe_q;
    assign probe_fall = ~r_probe_q & p_probe_q;

`ifdef POP_MON_SAMPLE_CHECK_EN
    logic r_sample_q;
    always_ff @(posedge clk) begin
        if (reset) r_sample_q <= 1'b0;
        else       r_sample_q <= pop_io.sample;
    end
    assign sample_bad = (state_q == S_PROBE) && r_probe_q && !r_sample_q;
`else
    assign sample_bad = 1'b0;
`endif

    // Violation priority: the lowest code wins when several coincide.
    always_comb begin
        err_d = 3'd0;
        if (state_q == S_PUMP && r_mw_q)
            err_d = 3'd1;
        else if (probe_rise && (state_q inside {S_PUMP, S_WAIT_MW1, S_MW1, S_RAMSEY, S_MW2}))
            err_d = 3'd2;
        else if (pump_rise && state_q != S_IDLE)
            err_d = 3'd3;
        else if (state_q != S_IDLE && tmo_q == TMO_W'(TIMEOUT))
            err_d = 3'd4;
        else if (sample_bad)
            err_d = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            r_pump_q       <= 1'b0;
            p_pump_q       <= 1'b0;
            r_mw_q         <= 1'b0;
            p_mw_q         <= 1'b0;
            r_probe_q      <= 1'b0;
            p_probe_q      <= 1'b0;
            live_q         <= 1'b0;
            armed_q        <= 1'b0;
            tmo_q          <= '0;
            pump_len_q     <= '0;
            mw1_len_q      <= '0;
            ramsey_len_q   <= '0;
            mw2_len_q      <= '0;
            probe_len_q    <= '0;
            result_valid_q <= 1'b0;
            seq_error_q    <= 1'b0;
            error_code_q   <= 3'd0;
            cycle_count_q  <= 16'd0;
        end else begin
            r_pump_q       <= pop_io.pump;
            p_pump_q       <= r_pump_q;
            r_mw_q         <= pop_io.MW;
            p_mw_q         <= r_mw_q;
            r_probe_q      <= pop_io.probe;
            p_probe_q      <= r_probe_q;
            live_q         <= 1'b1;
            // Only a pump seen low after reset exit may start a cycle.
            if (live_q && !r_pump_q) armed_q <= 1'b1;
            result_valid_q <= 1'b0;
            seq_error_q    <= 1'b0;
            tmo_q          <= tmo_q + TMO_W'(1);

            if (err_d != 3'd0) begin
                seq_error_q  <= 1'b1;
                error_code_q <= err_d;
                tmo_q        <= '0;
                if (err_d == 3'd3) begin
                    state_q    <= S_PUMP;
                    pump_cnt_q <= CNT_W'(1);
                end else begin
                    state_q <= S_IDLE;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tmo_q <= '0;
                        if (pump_rise && armed_q) begin
                            state_q    <= S_PUMP;
                            pump_cnt_q <= CNT_W'(1);
                        end
                    end
                    S_PUMP: begin
                        if (pump_fall) begin
                            state_q <= S_WAIT_MW1;
                            tmo_q   <= '0;
                        end else pump_cnt_q <= sat_inc(pump_cnt_q);
                    end
                    S_WAIT_MW1: begin
                        if (mw_rise) begin
                            state_q   <= S_MW1;
                            mw1_cnt_q <= CNT_W'(1);
                            tmo_q     <= '0;
                        end
                    end
                    S_MW1: begin
                        if (mw_fall) begin
                            state_q      <= S_RAMSEY;
                            ramsey_cnt_q <= CNT_W'(1);
                            tmo_q        <= '0;
                        end else mw1_cnt_q <= sat_inc(mw1_cnt_q);
                    end
                    S_RAMSEY: begin
                        if (mw_rise) begin
                            state_q   <= S_MW2;
                            mw2_cnt_q <= CNT_W'(1);
                            tmo_q     <= '0;
                        end else ramsey_cnt_q <= sat_inc(ramsey_cnt_q);
                    end
                    S_MW2: begin
                        if (mw_fall) begin
                            state_q <= S_WAIT_PROBE;
                            tmo_q   <= '0;
                        end else mw2_cnt_q <= sat_inc(mw2_cnt_q);
                    end
                    S_WAIT_PROBE: begin
                        if (probe_rise) begin
                            state_q     <= S_PROBE;
                            probe_cnt_q <= CNT_W'(1);
                            tmo_q       <= '0;
                        end
                    end
                    S_PROBE: begin
                        if (probe_fall) begin
                            state_q        <= S_IDLE;
                            tmo_q          <= '0;
                            pump_len_q     <= pump_cnt_q;
                            mw1_len_q      <= mw1_cnt_q;
                            ramsey_len_q   <= ramsey_cnt_q;
                            mw2_len_q      <= mw2_cnt_q;
                            probe_len_q    <= probe_cnt_q;
                            result_valid_q <= 1'b1;
                            cycle_count_q  <= cycle_count_q + 16'd1;
                        end else probe_cnt_q <= sat_inc(probe_cnt_q);
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pop_io.pump_len     = pump_len_q;
    assign pop_io.mw1_len      = mw1_len_q;
    assign pop_io.ramsey_len   = ramsey_len_q;
    assign pop_io.mw2_len      = mw2_len_q;
    assign pop_io.probe_len    = probe_len_q;
    assign pop_io.result_valid = result_valid_q;
    assign pop_io.seq_error    = seq_error_q;
    assign pop_io.error_code   = error_code_q;
    assign pop_io.cycle_count  = cycle_count_q;
endmodule
